microsequencer: RTL
===================

Name: microsequencer

Overview:
- Control-unit next-state engine. Owns the 7-bit state register that drives the microstore's state input.
- Consumes the microstore's next-state control fields, the instruction-decode dispatch target, the branch condition and the memory handshake. Produces the state for the next cycle.
- Sits between the instruction register/decoder and the microstore. The microstore decodes the state; this block generates it.

Parameters:
- STATE_W, 7, state register width.
- RESET_STATE, 0, state loaded on reset and on illegal dispatch.
- TIMEOUT, 255, MOC wait limit in cycles. Used only with MOC_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; 0 at posedge = reset
- n_sel  input  3  next-state mode from the microstore
- inv  input  1  condition invert from the microstore
- cr  input  STATE_W  branch/call target from the microstore
- cond  input  1  branch condition from the condition tester
- moc  input  1  memory operation complete
- dispatch_state  input  STATE_W  first state of the decoded instruction
- dispatch_valid  input  1  decoder recognised the opcode
- current_state  output  STATE_W  registered state to the microstore
- waiting  output  1  combinational; 1 while a wait mode holds the state
- illegal_op  output  1  registered one-cycle pulse on illegal dispatch
- timeout_err  output  1  registered one-cycle pulse on MOC timeout; constant 0 when the feature is compiled out

Behaviour:
- All state updates happen on posedge clk. reset==0 overrides everything.
- On reset:
  - current_state=RESET_STATE, ret_reg=0, illegal_op=0, timeout_err=0, wait counter=0.
  - A reset during a wait abandons the wait.
- Inputs are sampled in the same cycle they are presented, against the current_state that produced them through the combinational microstore. The new state is visible one cycle later. There is no other latency.
- inc = current_state+1, modulo 2^STATE_W, so 127 wraps to 0.
- Effective condition c = cond XOR inv.
- n_sel decode:
  - 000 DISPATCH: dispatch_valid=1 -> next=dispatch_state. dispatch_valid=0 -> next=RESET_STATE and illegal_op=1 for one cycle.
  - 001 INC: next=inc.
  - 010 JUMP: next=cr.
  - 011 BRANCH: c=1 -> next=cr; c=0 -> next=inc.
  - 100 WAIT_INC: moc=1 -> next=inc; moc=0 -> hold.
  - 101 WAIT_JUMP: moc=1 -> next=cr; moc=0 -> hold.
  - 110 CALL: ret_reg<=inc and next=cr, in the same edge.
  - 111 RETURN: next=ret_reg.
- Subroutine nesting depth is 1. A CALL issued inside a subroutine overwrites ret_reg; this is legal, with last-call-wins semantics.
- A RETURN with no prior CALL goes to ret_reg's reset value, 0.
- waiting = (n_sel is 100 or 101) AND moc==0 AND reset==1.
- moc is ignored in all non-wait modes.
- A wait mode with moc=1 on its first cycle advances immediately, with no wait cycle.
- cond, inv and cr are ignored in modes that do not use them.
- illegal_op and timeout_err are 0 in every cycle except their single event cycle.
- Arithmetic is unsigned throughout; no X propagation. An undefined n_sel is impossible because all 8 codes are defined.

Optional Feature:
- Macro: MOC_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter increments every cycle that waiting==1.
  - The counter clears on any cycle not waiting, and on reset.
  - When the counter reaches TIMEOUT while still waiting: next=RESET_STATE, timeout_err=1 for one cycle, counter cleared.
  - If moc arrives in that same cycle, moc wins: normal advance, no error.
- Undefined:
  - No counter. The wait holds indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with n_sel=001 -> current_state=0, illegal_op=0. Release -> states 1, 2, 3 on successive edges. Force state 127 via JUMP cr=127, then INC -> 0.
- Dispatch: state 1, n_sel=000, dispatch_state=6, valid=1 -> 6. Same with valid=0 -> state 0 and illegal_op high exactly 1 cycle.
- Branch: cr=12, n_sel=011, at state 8:
  - cond=1, inv=0 -> 12.
  - cond=1, inv=1 -> 9.
  - cond=0, inv=1 -> 12.
- Wait: state 3, n_sel=100, moc=0 for 4 cycles -> state stays 3, waiting=1. moc=1 -> 4, waiting=0. WAIT_JUMP with cr=5 and moc=1 at first cycle -> 5 next edge.
- Call/return: state 10, n_sel=110, cr=20 -> 20 and ret_reg=11. Later n_sel=111 -> 11. Reset mid-wait at state 3 -> 0 and waiting=0.
- MOC_TIMEOUT_EN, TIMEOUT=4: state 3, n_sel=100, moc held 0 -> after 4 wait cycles state=0 and timeout_err one-cycle pulse. Repeat with moc=1 on the 4th wait cycle -> state 4, no error.

Source files
------------

// File: rtl/microsequencer_if.sv
// Bus between the control unit (decoder, microstore, condition tester) and the
// microsequencer. The slave modport is the sequencer side; the master modport drives its inputs.
interface microsequencer_if #(
  parameter int STATE_W = 7
);
  logic [2:0]         n_sel;
  logic               inv;
  logic [STATE_W-1:0] cr;
  logic               cond;
  logic               moc;
  logic [STATE_W-1:0] dispatch_state;
  logic               dispatch_valid;
  logic [STATE_W-1:0] current_state;
  logic               waiting;
  logic               illegal_op;
  logic               timeout_err;

  modport master (
    output n_sel, inv, cr, cond, moc, dispatch_state, dispatch_valid,
    input  current_state, waiting, illegal_op, timeout_err
  );

  modport slave (
    input  n_sel, inv, cr, cond, moc, dispatch_state, dispatch_valid,
    output current_state, waiting, illegal_op, timeout_err
  );
endinterface

// File: rtl/microsequencer.sv
// Control-unit next-state engine: owns the microstore state register.
// Optional MOC wait timeout is compiled in with the MOC_TIMEOUT_EN macro.
module microsequencer #(
  parameter int          STATE_W     = 7,
  parameter int unsigned RESET_STATE = 0,
  parameter int          TIMEOUT     = 255
) (
  input logic             clk,
  input logic             reset,
  microsequencer_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_DISPATCH  = 3'b000,
    SEL_INC       = 3'b001,
    SEL_JUMP      = 3'b010,
    SEL_BRANCH    = 3'b011,
    SEL_WAIT_INC  = 3'b100,
    SEL_WAIT_JUMP = 3'b101,
    SEL_CALL      = 3'b110,
    SEL_RETURN    = 3'b111
  } sel_e;

  localparam logic [STATE_W-1:0] RST_STATE = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] r_ret;
  logic               r_illegal;
  logic [STATE_W-1:0] w_inc;
  logic [STATE_W-1:0] w_next;
  logic [STATE_W-1:0] w_ret_next;
  logic               w_illegal;
  logic               w_cond;
  logic               w_wait_mode;
  logic               w_waiting;
  logic               w_timeout;
  sel_e               w_sel;

  assign w_sel       = sel_e'(bus.n_sel);
  assign w_inc       = r_state + {{(STATE_W-1){1'b0}}, 1'b1};
  assign w_cond      = bus.cond ^ bus.inv;
  assign w_wait_mode = (w_sel == SEL_WAIT_INC) || (w_sel == SEL_WAIT_JUMP);
  assign w_waiting   = w_wait_mode && !bus.moc && reset;

  // Next-state selection from the microstore's sequencing field.
  always_comb begin
    w_next     = r_state;
    w_ret_next = r_ret;
    w_illegal  = 1'b0;
    case (w_sel)
      SEL_DISPATCH: begin
        if (bus.dispatch_valid) begin
          w_next = bus.dispatch_state;
        end else begin
          w_next    = RST_STATE;
          w_illegal = 1'b1;
        end
      end
      SEL_INC:  w_next = w_inc;
      SEL_JUMP: w_next = bus.cr;
      SEL_BRANCH: begin
        if (w_cond) begin
          w_next = bus.cr;
        end else begin
          w_next = w_inc;
        end
      end
      SEL_WAIT_INC: begin
        if (bus.moc) begin
          w_next = w_inc;
        end else begin
          w_next = r_state;
        end
      end
      SEL_WAIT_JUMP: begin
        if (bus.moc) begin
          w_next = bus.cr;
        end else begin
          w_next = r_state;
        end
      end
      SEL_CALL: begin
        w_ret_next = w_inc;
        w_next     = bus.cr;
      end
      SEL_RETURN: w_next = r_ret;
      default: begin
        w_next     = RST_STATE;
        w_ret_next = r_ret;
        w_illegal  = 1'b0;
      end
    endcase
  end

`ifdef MOC_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  // Fires on the wait cycle that brings the counter up to TIMEOUT; a moc in
  // that cycle means we are not waiting, so the normal advance wins.
  assign w_timeout = w_waiting && ((r_wait_cnt + 8'd1) == 8'(TIMEOUT));

  // Consecutive-wait-cycle counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_waiting && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  assign bus.timeout_err = r_timeout;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // State, return-address and illegal-dispatch registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= RST_STATE;
      r_ret     <= {STATE_W{1'b0}};
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_timeout ? RST_STATE : w_next;
      r_ret     <= w_ret_next;
      r_illegal <= w_illegal;
    end
  end

  assign bus.current_state = r_state;
  assign bus.waiting       = w_waiting;
  assign bus.illegal_op    = r_illegal;

endmodule
